pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RV64 pipeline (F, D, E, M, W).
- Produces per-stage stall/bubble controls for the F/D/E/M/W pipeline registers.
- Detects load-use hazards that decode forwarding cannot cover.
- Issues fetch redirects for taken branches and jumps resolved in E.
- Sequences the multi-cycle mul/div unit with a start/done handshake.
- Freezes the pipeline while data memory is not ready.

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_if.sv | 54 +++++
 rtl/pipeline_ctrl_md_seq.sv | 66 ++++++
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// opcode_info bit positions, the mul/div alu_info mask and the FSM encoding.
package pipeline_ctrl_pkg;

    localparam int unsigned OPC_W      = 12;
    localparam int unsigned OPC_BRANCH = 1;
    localparam int unsigned OPC_STORE  = 2;
    localparam int unsigned OPC_LOAD   = 3;
    localparam int unsigned OPC_JALR   = 8;
    localparam int unsigned OPC_JAL    = 9;

    localparam int unsigned ALU_INFO_W = 20;
    // alu_info[12:0] are the mul/div/rem variants
    localparam logic [ALU_INFO_W-1:0] ALU_MULDIV_MASK = 20'h01FFF;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } md_state_e;

    function automatic logic is_muldiv_op(input logic [ALU_INFO_W-1:0] alu_info);
        return |(alu_info & ALU_MULDIV_MASK);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline status inputs and stage control outputs of the hazard controller.
// slave = controller side, master = pipeline side.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       decode_i_rs1;
    logic [4:0]       decode_i_rs2;
    logic [4:0]       regE_i_rd;
    logic             regE_i_reg_wen;
    logic [11:0]      regE_i_opcode_info;
    logic             regE_i_is_muldiv;
    logic [11:0]      regM_i_opcode_info;
    logic             execute_i_redirect;
    logic [63:0]      execute_i_redirect_pc;
    logic             muldiv_i_done;
    logic             dmem_i_ready;

    logic             muldiv_o_start;
    logic             fetch_o_redirect;
    logic [63:0]      fetch_o_redirect_pc;
    logic             regF_o_stall;
    logic             regD_o_stall;
    logic             regD_o_bubble;
    logic             regE_o_stall;
    logic             regE_o_bubble;
    logic             regM_o_stall;
    logic             regM_o_bubble;
    logic             regW_o_bubble;
    logic [CNT_W-1:0] ctrl_o_stall_cnt;
    logic [CNT_W-1:0] ctrl_o_flush_cnt;

    modport slave (
        input  decode_i_rs1, decode_i_rs2, regE_i_rd, regE_i_reg_wen,
               regE_i_opcode_info, regE_i_is_muldiv, regM_i_opcode_info,
               execute_i_redirect, execute_i_redirect_pc, muldiv_i_done,
               dmem_i_ready,
        output muldiv_o_start, fetch_o_redirect, fetch_o_redirect_pc,
               regF_o_stall, regD_o_stall, regD_o_bubble, regE_o_stall,
               regE_o_bubble, regM_o_stall, regM_o_bubble, regW_o_bubble,
               ctrl_o_stall_cnt, ctrl_o_flush_cnt
    );

    modport master (
        output decode_i_rs1, decode_i_rs2, regE_i_rd, regE_i_reg_wen,
               regE_i_opcode_info, regE_i_is_muldiv, regM_i_opcode_info,
               execute_i_redirect, execute_i_redirect_pc, muldiv_i_done,
               dmem_i_ready,
        input  muldiv_o_start, fetch_o_redirect, fetch_o_redirect_pc,
               regF_o_stall, regD_o_stall, regD_o_bubble, regE_o_stall,
               regE_o_bubble, regM_o_stall, regM_o_bubble, regW_o_bubble,
               ctrl_o_stall_cnt, ctrl_o_flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_md_seq.sv
// Mul/div sequencer: RUN/MD_WAIT FSM, start pulse and the done-hold flag that
// stops a completed mul/div from restarting while the pipe is frozen.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl_md_seq (
    input  logic clk,
    input  logic rst_n,
    input  logic is_muldiv,
    input  logic muldiv_done,
    input  logic mem_freeze,
    input  logic e_stall,
    output logic md_busy,
    output logic muldiv_start
);

    md_state_e state_q, state_d;
    logic      hold_q, hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!e_stall)
            hold_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (is_muldiv && !hold_q && !mem_freeze)
                    state_d = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                // E cannot advance under a freeze, so remember the result is taken
                if (muldiv_done) begin
                    state_d = ST_RUN;
                    if (mem_freeze)
                        hold_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        md_busy      = 1'b0;
        muldiv_start = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    md_busy      = is_muldiv && !hold_q;
                    muldiv_start = is_muldiv && !hold_q && !mem_freeze;
                end
                ST_MD_WAIT: md_busy = !muldiv_done;
                default: md_busy = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: prioritised
// stall/bubble/redirect generation plus stall and flush counters.
import pipeline_ctrl_pkg::*;

module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    logic             mem_freeze;
    logic             md_busy;
    logic             md_start;
    logic             load_use;
    logic             redirect;
    logic             f_stall, d_stall, d_bubble, e_stall, e_bubble;
    logic             m_stall, m_bubble, w_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             unused_opc;

    assign mem_freeze = (bus.regM_i_opcode_info[OPC_LOAD] | bus.regM_i_opcode_info[OPC_STORE])
                        & ~bus.dmem_i_ready;

    assign load_use = bus.regE_i_opcode_info[OPC_LOAD] & bus.regE_i_reg_wen
                      & (bus.regE_i_rd != 5'd0)
                      & ((bus.regE_i_rd == bus.decode_i_rs1) | (bus.regE_i_rd == bus.decode_i_rs2));

    assign unused_opc = ^{bus.regE_i_opcode_info[11:4], bus.regE_i_opcode_info[2:0],
                          bus.regM_i_opcode_info[11:4], bus.regM_i_opcode_info[1:0]};

    pipeline_ctrl_md_seq u_md_seq (
        .clk          (clk),
        .rst_n        (rst),
        .is_muldiv    (bus.regE_i_is_muldiv),
        .muldiv_done  (bus.muldiv_i_done),
        .mem_freeze   (mem_freeze),
        .e_stall      (e_stall),
        .md_busy      (md_busy),
        .muldiv_start (md_start)
    );

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_stall  = 1'b0;
        e_bubble = 1'b0;
        m_stall  = 1'b0;
        m_bubble = 1'b0;
        w_bubble = 1'b0;
        redirect = 1'b0;
        if (!rst) begin
            redirect = 1'b0;
        end else if (mem_freeze) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_stall  = 1'b1;
            w_bubble = 1'b1;
        end else if (md_busy) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_stall  = 1'b1;
            m_bubble = 1'b1;
        end else if (bus.execute_i_redirect) begin
            // squash D and E; a coincident load-use belongs to a squashed instruction
            redirect = 1'b1;
            d_bubble = 1'b1;
            e_bubble = 1'b1;
        end else if (load_use) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (f_stall)
                stall_cnt <= stall_cnt + 1'b1;
            if (redirect)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.muldiv_o_start      = md_start;
    assign bus.fetch_o_redirect    = redirect;
    assign bus.fetch_o_redirect_pc = redirect ? bus.execute_i_redirect_pc : '0;
    assign bus.regF_o_stall        = f_stall;
    assign bus.regD_o_stall        = d_stall;
    assign bus.regD_o_bubble       = d_bubble;
    assign bus.regE_o_stall        = e_stall;
    assign bus.regE_o_bubble       = e_bubble;
    assign bus.regM_o_stall        = m_stall;
    assign bus.regM_o_bubble       = m_bubble;
    assign bus.regW_o_bubble       = w_bubble;
    assign bus.ctrl_o_stall_cnt    = stall_cnt;
    assign bus.ctrl_o_flush_cnt    = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: inputs change on the falling
// edge, combinational controls are checked 1 ns later.
module tb_pipeline_ctrl;

    // ctrl vector: {start, redirect, F_st, D_st, D_bub, E_st, E_bub, M_st, M_bub, W_bub}
    localparam logic [9:0] C_IDLE   = 10'h000;
    localparam logic [9:0] C_LDUSE  = 10'h0C8;
    localparam logic [9:0] C_REDIR  = 10'h128;
    localparam logic [9:0] C_BUSY   = 10'h0D2;
    localparam logic [9:0] C_START  = 10'h2D2;
    localparam logic [9:0] C_FREEZE = 10'h0D5;

    logic clk;
    logic rst_n;
    int   nassert;
    int   nfail;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl_vec();
        return {bus.muldiv_o_start, bus.fetch_o_redirect, bus.regF_o_stall,
                bus.regD_o_stall, bus.regD_o_bubble, bus.regE_o_stall,
                bus.regE_o_bubble, bus.regM_o_stall, bus.regM_o_bubble,
                bus.regW_o_bubble};
    endfunction

    task automatic set_idle();
        bus.decode_i_rs1          = 5'd0;
        bus.decode_i_rs2          = 5'd0;
        bus.regE_i_rd             = 5'd0;
        bus.regE_i_reg_wen        = 1'b0;
        bus.regE_i_opcode_info    = 12'h000;
        bus.regE_i_is_muldiv      = 1'b0;
        bus.regM_i_opcode_info    = 12'h000;
        bus.execute_i_redirect    = 1'b0;
        bus.execute_i_redirect_pc = 64'd0;
        bus.muldiv_i_done         = 1'b0;
        bus.dmem_i_ready          = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.execute_i_redirect    = 1'b1;
        bus.execute_i_redirect_pc = 64'h0000_0000_8000_0040;
        bus.regE_i_is_muldiv      = 1'b1;
        #1;
        nassert++;
        if (ctrl_vec() !== C_IDLE) begin
            nfail++;
            $display("FAIL reset_ctrl: got %h exp %h", ctrl_vec(), C_IDLE);
        end
        nassert++;
        if (bus.fetch_o_redirect_pc !== 64'd0) begin
            nfail++;
            $display("FAIL reset_pc: got %h exp 0", bus.fetch_o_redirect_pc);
        end
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd0 || bus.ctrl_o_flush_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL reset_cnt: got %0d/%0d exp 0/0", bus.ctrl_o_stall_cnt, bus.ctrl_o_flush_cnt);
        end
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        logic [9:0] exp_v [5] = '{C_LDUSE, C_IDLE, C_IDLE, C_LDUSE, C_IDLE};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_idle();
            case (i)
                0: begin bus.regE_i_opcode_info = 12'h008; bus.regE_i_reg_wen = 1'b1;
                          bus.regE_i_rd = 5'd5; bus.decode_i_rs1 = 5'd5; end
                2: begin bus.regE_i_opcode_info = 12'h008; bus.regE_i_reg_wen = 1'b1;
                          bus.regE_i_rd = 5'd0; bus.decode_i_rs1 = 5'd0; end
                3: begin bus.regE_i_opcode_info = 12'h008; bus.regE_i_reg_wen = 1'b1;
                          bus.regE_i_rd = 5'd7; bus.decode_i_rs1 = 5'd3; bus.decode_i_rs2 = 5'd7; end
                4: begin bus.regE_i_opcode_info = 12'h000; bus.regE_i_reg_wen = 1'b1;
                          bus.regE_i_rd = 5'd7; bus.decode_i_rs2 = 5'd7; end
                default: ;
            endcase
            #1;
            nassert++;
            if (ctrl_vec() !== exp_v[i]) begin
                nfail++;
                $display("FAIL load_use_ctrl[%0d]: got %h exp %h", i, ctrl_vec(), exp_v[i]);
            end
            if (i == 1) begin
                nassert++;
                if (bus.ctrl_o_stall_cnt !== 32'd1) begin
                    nfail++;
                    $display("FAIL load_use_cnt1: got %0d exp 1", bus.ctrl_o_stall_cnt);
                end
            end
        end
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd2) begin
            nfail++;
            $display("FAIL load_use_cnt2: got %0d exp 2", bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        bus.execute_i_redirect    = 1'b1;
        bus.execute_i_redirect_pc = 64'h0000_0000_8000_0040;
        #1;
        nassert++;
        if (ctrl_vec() !== C_REDIR || bus.fetch_o_redirect_pc !== 64'h0000_0000_8000_0040) begin
            nfail++;
            $display("FAIL redirect: got %h pc %h exp %h pc 80000040", ctrl_vec(), bus.fetch_o_redirect_pc, C_REDIR);
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (ctrl_vec() !== C_IDLE || bus.ctrl_o_flush_cnt !== 32'd1) begin
            nfail++;
            $display("FAIL redirect_after: got %h flush %0d exp %h flush 1", ctrl_vec(), bus.ctrl_o_flush_cnt, C_IDLE);
        end
        @(negedge clk);
        bus.execute_i_redirect    = 1'b1;
        bus.execute_i_redirect_pc = 64'h0000_0000_0000_1000;
        bus.regE_i_opcode_info    = 12'h008;
        bus.regE_i_reg_wen        = 1'b1;
        bus.regE_i_rd             = 5'd9;
        bus.decode_i_rs2          = 5'd9;
        #1;
        nassert++;
        if (ctrl_vec() !== C_REDIR) begin
            nfail++;
            $display("FAIL redirect_vs_load_use: got %h exp %h", ctrl_vec(), C_REDIR);
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_flush_cnt !== 32'd2 || bus.ctrl_o_stall_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL redirect_cnt: got flush %0d stall %0d exp 2/0", bus.ctrl_o_flush_cnt, bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_muldiv();
        int starts;
        logic [9:0] exp_c;
        starts = 0;
        do_reset();
        for (int i = 0; i <= 34; i++) begin
            @(negedge clk);
            bus.regE_i_is_muldiv = 1'b1;
            bus.muldiv_i_done    = (i == 34);
            exp_c = (i == 0) ? C_START : (i == 34) ? C_IDLE : C_BUSY;
            #1;
            if (bus.muldiv_o_start === 1'b1) starts++;
            nassert++;
            if (ctrl_vec() !== exp_c) begin
                nfail++;
                $display("FAIL muldiv_ctrl[%0d]: got %h exp %h", i, ctrl_vec(), exp_c);
            end
        end
        nassert++;
        if (starts !== 1) begin
            nfail++;
            $display("FAIL muldiv_starts: got %0d exp 1", starts);
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd34) begin
            nfail++;
            $display("FAIL muldiv_stall_cnt: got %0d exp 34", bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_v [5] = '{C_START, C_IDLE, C_START, C_BUSY, C_IDLE};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.regE_i_is_muldiv = 1'b1;
            bus.muldiv_i_done    = (i == 1) || (i == 4);
            #1;
            nassert++;
            if (ctrl_vec() !== exp_v[i]) begin
                nfail++;
                $display("FAIL back_to_back[%0d]: got %h exp %h", i, ctrl_vec(), exp_v[i]);
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd3) begin
            nfail++;
            $display("FAIL back_to_back_cnt: got %0d exp 3", bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_done_mem_wait();
        logic [9:0] exp_v [11] = '{C_START, C_BUSY, C_BUSY, C_BUSY, C_FREEZE, C_FREEZE,
                                   C_FREEZE, C_IDLE, C_IDLE, C_START, C_IDLE};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_idle();
            bus.regE_i_is_muldiv   = (i <= 7) || (i >= 9);
            bus.regM_i_opcode_info = (i >= 4 && i <= 7) ? 12'h004 : 12'h000;
            bus.dmem_i_ready       = !(i >= 4 && i <= 6);
            bus.muldiv_i_done      = (i == 5) || (i == 10);
            #1;
            nassert++;
            if (ctrl_vec() !== exp_v[i]) begin
                nfail++;
                $display("FAIL done_mem_wait[%0d]: got %h exp %h", i, ctrl_vec(), exp_v[i]);
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd8) begin
            nfail++;
            $display("FAIL done_mem_wait_cnt: got %0d exp 8", bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_redirect_freeze();
        logic [9:0] exp_v [3] = '{C_FREEZE, C_FREEZE, C_REDIR};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.regM_i_opcode_info    = 12'h008;
            bus.dmem_i_ready          = (i == 2);
            bus.execute_i_redirect    = 1'b1;
            bus.execute_i_redirect_pc = 64'h0000_0000_8000_0100;
            #1;
            nassert++;
            if (ctrl_vec() !== exp_v[i]) begin
                nfail++;
                $display("FAIL redirect_freeze[%0d]: got %h exp %h", i, ctrl_vec(), exp_v[i]);
            end
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_flush_cnt !== 32'd1 || bus.ctrl_o_stall_cnt !== 32'd2) begin
            nfail++;
            $display("FAIL redirect_freeze_cnt: got flush %0d stall %0d exp 1/2", bus.ctrl_o_flush_cnt, bus.ctrl_o_stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.regE_i_is_muldiv = 1'b1;
        end
        #1;
        nassert++;
        if (ctrl_vec() !== C_BUSY) begin
            nfail++;
            $display("FAIL async_pre: got %h exp %h", ctrl_vec(), C_BUSY);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nassert++;
        if (ctrl_vec() !== C_IDLE || bus.ctrl_o_stall_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL async_reset: got %h stall %0d exp %h stall 0", ctrl_vec(), bus.ctrl_o_stall_cnt, C_IDLE);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nassert++;
        if (ctrl_vec() !== C_START) begin
            nfail++;
            $display("FAIL async_restart: got %h exp %h", ctrl_vec(), C_START);
        end
        @(negedge clk);
        bus.muldiv_i_done = 1'b1;
        #1;
        nassert++;
        if (ctrl_vec() !== C_IDLE) begin
            nfail++;
            $display("FAIL async_done: got %h exp %h", ctrl_vec(), C_IDLE);
        end
        @(negedge clk);
        set_idle();
        #1;
        nassert++;
        if (bus.ctrl_o_stall_cnt !== 32'd1) begin
            nfail++;
            $display("FAIL async_cnt: got %0d exp 1", bus.ctrl_o_stall_cnt);
        end
    endtask

    initial begin
        nassert = 0;
        nfail   = 0;
        rst_n   = 1'b0;
        set_idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_muldiv();
        test_back_to_back();
        test_done_mem_wait();
        test_redirect_freeze();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
